// File: rtl/warp_dispatcher.sv
// warp_dispatcher: buffers kernel launches, dispatches warps round-robin to idle SIMD cores
// and reports completions one per cycle, lowest core index first.
module warp_dispatcher #(
  parameter int CORE_COUNT   = 4,
  parameter int QUEUE_DEPTH  = 8,
  parameter int THREAD_COUNT = 16,
  parameter int IDX_W        = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1,
  parameter int TC_W         = $clog2(THREAD_COUNT) + 1,
  parameter int QC_W         = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       launch_valid,
  input  logic [3:0]                 launch_warp_id,
  input  logic [TC_W-1:0]            launch_thread_count,
  input  logic [31:0]                launch_start_pc,
  output logic                       launch_ready,
  output logic                       launch_err,
  output logic [CORE_COUNT-1:0]      core_start,
  output logic [4*CORE_COUNT-1:0]    core_warp_id,
  output logic [TC_W*CORE_COUNT-1:0] core_thread_count,
  output logic [32*CORE_COUNT-1:0]   core_start_pc,
  input  logic [CORE_COUNT-1:0]      core_finished,
  output logic                       done_valid,
  output logic [3:0]                 done_warp_id,
  output logic [IDX_W-1:0]           done_core,
  input  logic                       done_ready,
  output logic [QC_W-1:0]            queue_count,
  output logic                       all_idle
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q [CORE_COUNT];
  state_t state_d [CORE_COUNT];
  logic [3:0]      q_wid [QUEUE_DEPTH];
  logic [TC_W-1:0] q_tc  [QUEUE_DEPTH];
  logic [31:0]     q_pc  [QUEUE_DEPTH];
  logic [3:0]      d_wid [CORE_COUNT];
  logic [TC_W-1:0] d_tc  [CORE_COUNT];
  logic [31:0]     d_pc  [CORE_COUNT];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [IDX_W-1:0] rr_ptr, target, sel;
  logic legal, accept, push, pop, found, retire, any_busy;

  assign launch_ready = queue_count != QC_W'(QUEUE_DEPTH);
  assign legal = launch_warp_id != 4'hF && launch_thread_count != '0 &&
                 launch_thread_count <= TC_W'(THREAD_COUNT);
  assign accept = launch_valid && launch_ready;
  assign push = accept && legal;
  assign pop = queue_count != '0 && found;
  assign retire = done_valid && done_ready;
  assign done_warp_id = done_valid ? d_wid[sel] : 4'h0;
  assign done_core = sel;
  assign all_idle = queue_count == '0 && !any_busy;

  // Searching downward lets the nearest idle core after rr_ptr win the last assignment.
  always_comb begin
    found = 1'b0;
    target = '0;
    sel = '0;
    done_valid = 1'b0;
    any_busy = 1'b0;
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      if (state_q[(int'(rr_ptr) + k) % CORE_COUNT] == IDLE) begin
        found = 1'b1;
        target = IDX_W'((int'(rr_ptr) + k) % CORE_COUNT);
      end
      if (state_q[k] == DONE) begin
        done_valid = 1'b1;
        sel = IDX_W'(k);
      end
      if (state_q[k] != IDLE) any_busy = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      state_d[i] = state_q[i];
      if (pop && target == IDX_W'(i)) state_d[i] = BUSY;
      else if (state_q[i] == BUSY && core_finished[i]) state_d[i] = DONE;
      else if (retire && sel == IDX_W'(i)) state_d[i] = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_wid[wr_ptr] <= launch_warp_id;
      q_tc[wr_ptr] <= launch_thread_count;
      q_pc[wr_ptr] <= launch_start_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      queue_count <= '0;
      rr_ptr <= '0;
      launch_err <= 1'b0;
      core_start <= '0;
      for (int i = 0; i < CORE_COUNT; i++) begin
        state_q[i] <= IDLE;
        d_wid[i] <= 4'hF;
        d_tc[i] <= '0;
        d_pc[i] <= '0;
      end
    end else begin
      launch_err <= accept && !legal;
      core_start <= '0;
      queue_count <= queue_count + QC_W'(push) - QC_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rr_ptr <= (target == IDX_W'(CORE_COUNT - 1)) ? '0 : target + 1'b1;
        core_start[target] <= 1'b1;
        d_wid[target] <= q_wid[rd_ptr];
        d_tc[target] <= q_tc[rd_ptr];
        d_pc[target] <= q_pc[rd_ptr];
      end
      if (retire) begin
        d_wid[sel] <= 4'hF;
        d_tc[sel] <= '0;
        d_pc[sel] <= '0;
      end
      for (int i = 0; i < CORE_COUNT; i++) state_q[i] <= state_d[i];
    end
  end

  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_core
    assign core_warp_id[4*i +: 4] = d_wid[i];
    assign core_thread_count[TC_W*i +: TC_W] = d_tc[i];
    assign core_start_pc[32*i +: 32] = d_pc[i];
  end
endmodule

// File: tb/tb_warp_dispatcher.sv
// tb_warp_dispatcher: directed and random launches checked against a queue-based model of
// the dispatcher; the monitor samples on the falling edge.
module tb_warp_dispatcher;
  localparam int NC = 4;
  localparam int QD = 8;
  localparam int TCMAX = 16;
  localparam int TCW = 5;

  logic clk = 0;
  logic rst;
  logic launch_valid;
  logic [3:0] launch_warp_id;
  logic [TCW-1:0] launch_thread_count;
  logic [31:0] launch_start_pc;
  logic launch_ready, launch_err;
  logic [NC-1:0] core_start;
  logic [4*NC-1:0] core_warp_id;
  logic [TCW*NC-1:0] core_thread_count;
  logic [32*NC-1:0] core_start_pc;
  logic [NC-1:0] core_finished;
  logic done_valid;
  logic [3:0] done_warp_id;
  logic [1:0] done_core;
  logic done_ready;
  logic [3:0] queue_count;
  logic all_idle;

  warp_dispatcher #(.CORE_COUNT(NC), .QUEUE_DEPTH(QD), .THREAD_COUNT(TCMAX)) dut (
    .clk(clk), .rst(rst), .launch_valid(launch_valid), .launch_warp_id(launch_warp_id),
    .launch_thread_count(launch_thread_count), .launch_start_pc(launch_start_pc),
    .launch_ready(launch_ready), .launch_err(launch_err), .core_start(core_start),
    .core_warp_id(core_warp_id), .core_thread_count(core_thread_count),
    .core_start_pc(core_start_pc), .core_finished(core_finished), .done_valid(done_valid),
    .done_warp_id(done_warp_id), .done_core(done_core), .done_ready(done_ready),
    .queue_count(queue_count), .all_idle(all_idle));

  always #5 clk = ~clk;

  typedef struct {logic [3:0] wid; logic [TCW-1:0] tc; logic [31:0] pc;} desc_t;
  desc_t exp_q[$];
  desc_t cd[NC];
  desc_t p_new;
  int st[NC];
  int rr, p_tgt, p_ret;
  bit p_disp, p_push, p_err;
  bit [NC-1:0] p_fin;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Model: st[] is 0 idle, 1 busy, 2 done; exp_q holds queued launches in order.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      for (int i = 0; i < NC; i++) st[i] = 0;
      rr = 0; p_disp = 0; p_push = 0; p_err = 0; p_fin = '0; p_ret = -1;
      chk("rst_ready", launch_ready, 1);
      chk("rst_err", launch_err, 0);
      chk("rst_start", core_start, 0);
      chk("rst_wid", core_warp_id, 16'hFFFF);
      chk("rst_tc", core_thread_count, 0);
      chk("rst_pc", core_start_pc, 0);
      chk("rst_done", {done_valid, done_warp_id, done_core}, 0);
      chk("rst_qc", queue_count, 0);
      chk("rst_idle", all_idle, 1);
    end else begin
      int low;
      bit busy_any, acc, legal;
      chk("core_start", core_start, p_disp ? (4'b1 << p_tgt) : 4'b0);
      if (p_disp) begin
        cd[p_tgt] = exp_q.pop_front();
        st[p_tgt] = 1;
        rr = (p_tgt + 1) % NC;
      end
      for (int i = 0; i < NC; i++) if (p_fin[i]) st[i] = 2;
      if (p_ret >= 0) st[p_ret] = 0;
      if (p_push) exp_q.push_back(p_new);
      chk("launch_err", launch_err, p_err);
      chk("queue_count", queue_count, exp_q.size());
      chk("launch_ready", launch_ready, exp_q.size() != QD);
      low = -1;
      busy_any = 0;
      for (int i = NC - 1; i >= 0; i--) begin
        if (st[i] == 2) low = i;
        if (st[i] != 0) busy_any = 1;
      end
      chk("done_valid", done_valid, low >= 0);
      chk("done_core", done_core, low >= 0 ? low : 0);
      chk("done_warp_id", done_warp_id, low >= 0 ? cd[low].wid : 0);
      chk("all_idle", all_idle, exp_q.size() == 0 && !busy_any);
      for (int i = 0; i < NC; i++) begin
        chk("desc_wid", core_warp_id[4*i +: 4], st[i] != 0 ? cd[i].wid : 4'hF);
        chk("desc_tc", core_thread_count[TCW*i +: TCW], st[i] != 0 ? cd[i].tc : 0);
        chk("desc_pc", core_start_pc[32*i +: 32], st[i] != 0 ? cd[i].pc : 0);
      end
      p_disp = 0;
      p_tgt = 0;
      if (exp_q.size() != 0)
        for (int k = 0; k < NC; k++)
          if (!p_disp && st[(rr + k) % NC] == 0) begin
            p_disp = 1;
            p_tgt = (rr + k) % NC;
          end
      for (int i = 0; i < NC; i++) p_fin[i] = core_finished[i] && st[i] == 1;
      p_ret = (done_ready && low >= 0) ? low : -1;
      acc = launch_valid && exp_q.size() != QD;
      legal = launch_warp_id != 4'hF && launch_thread_count != 0 && launch_thread_count <= TCMAX;
      p_push = acc && legal;
      p_err = acc && !legal;
      p_new = '{launch_warp_id, launch_thread_count, launch_start_pc};
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [3:0] w, input logic [TCW-1:0] t, input logic [31:0] pc);
    launch_valid = 1;
    launch_warp_id = w;
    launch_thread_count = t;
    launch_start_pc = pc;
    cyc();
    launch_valid = 0;
  endtask

  task automatic drain(input int n);
    done_ready = 1;
    repeat (n) begin
      core_finished = '1;
      cyc();
      core_finished = '0;
      cyc();
    end
  endtask

  initial begin
    rst = 0;
    launch_valid = 0;
    launch_warp_id = 0;
    launch_thread_count = 0;
    launch_start_pc = 0;
    core_finished = 0;
    done_ready = 0;
    cyc(2);
    rst = 1;
    cyc(2);
    launch(4'd1, 5'd4, 32'h1234_5678);
    cyc(3);
    drain(3);
    done_ready = 0;
    for (int w = 1; w <= 6; w++) launch(w[3:0], 5'd8, 32'h100 * w);
    cyc(2);
    core_finished = 4'b0100;
    cyc();
    core_finished = 0;
    done_ready = 1;
    cyc(4);
    drain(10);
    done_ready = 0;
    for (int w = 0; w < 13; w++) launch(w[3:0], 5'd16, $urandom);
    launch_valid = 1;
    cyc(3);
    core_finished = 4'b0001;
    cyc();
    core_finished = 0;
    done_ready = 1;
    cyc(4);
    launch_valid = 0;
    drain(12);
    launch(4'hF, 5'd4, 32'h1);
    cyc();
    launch(4'd3, 5'd0, 32'h2);
    cyc();
    launch(4'd3, 5'd17, 32'h3);
    cyc(2);
    done_ready = 0;
    for (int w = 0; w < 4; w++) launch(w[3:0], 5'd2, 32'hA0 + w);
    cyc(2);
    core_finished = 4'b1010;
    cyc();
    core_finished = 0;
    cyc(3);
    done_ready = 1;
    cyc(4);
    drain(4);
    core_finished = 4'b1111;
    cyc(2);
    core_finished = 0;
    cyc(2);
    for (int w = 1; w <= 7; w++) launch(w[3:0], 5'd1, 32'hC0 + w);
    core_finished = 4'b0011;
    cyc();
    core_finished = 0;
    #3 rst = 0;
    cyc(2);
    rst = 1;
    cyc(4);
    for (int n = 0; n < 2000; n++) begin
      launch_valid = $urandom_range(0, 1);
      launch_warp_id = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      launch_thread_count = 5'($urandom_range(0, 17));
      launch_start_pc = $urandom;
      core_finished = 4'($urandom) & 4'($urandom);
      done_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    launch_valid = 0;
    drain(20);
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
